// File: rtl/board_memory_ctrl_pkg.sv
// board_mem_pkg: op/err codes, FSM states and width helpers shared by the
// board memory controller and its snapshot bank.
package board_mem_pkg;

  typedef enum logic [2:0] {
    OP_TABLE_TAKE = 3'd0,
    OP_TABLE_DOWN = 3'd1,
    OP_SHIFT      = 3'd2,
    OP_HAND_TAKE  = 3'd3,
    OP_HAND_DOWN  = 3'd4,
    OP_DRAW       = 3'd5,
    OP_COMMIT     = 3'd6,
    OP_RESTORE    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_EMPTY_SRC   = 3'd1,
    ERR_NO_PICK     = 3'd2,
    ERR_OCCUPIED    = 3'd3,
    ERR_RANGE       = 3'd4,
    ERR_UNAVAIL     = 3'd5,
    ERR_UNSUPPORTED = 3'd6
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT
  } state_e;

  // Width of every hand/deck counter.
  localparam int unsigned CNT_W = 7;

  // Index width for n items, never below one bit (PW/XW/YW).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Shift-length width: must hold the full column count (LW).
  function automatic int unsigned len_w(input int unsigned cols);
    return idx_w(cols) + 1;
  endfunction

endpackage

// File: rtl/board_memory_ctrl_snapshot.sv
// board_snapshot: committed copy of the table grid and hand counters.
// Loaded on commit; read back by the controller on restore.
module board_snapshot
  import board_mem_pkg::*;
#(
  parameter int unsigned CELLS  = 144,
  parameter int unsigned CARD_W = 6,
  parameter int unsigned CODES  = 54,
  parameter int unsigned HAND_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit,
  input  logic [CELLS*CARD_W-1:0] map_in,
  input  logic [HAND_W-1:0]       hand_in,
  output logic [CELLS*CARD_W-1:0] map_snap,
  output logic [HAND_W-1:0]       hand_snap
);

  // Snapshot register bank: empty table and zero hands after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        map_snap[i*CARD_W +: CARD_W] <= CARD_W'(CODES);
      end
      hand_snap <= '0;
    end else if (commit) begin
      map_snap  <= map_in;
      hand_snap <= hand_in;
    end
  end

endmodule

// File: rtl/board_memory_ctrl.sv
// board_memory_ctrl: table grid, per-player hand counts, deck count and
// drawn-card mask behind a single valid/ready command port.
// Optional macro BOARD_RESTORE_EN adds the committed-table snapshot used by
// COMMIT/RESTORE; without it RESTORE reports UNSUPPORTED.
module board_memory_ctrl
  import board_mem_pkg::*;
#(
  parameter int unsigned COLS        = 18,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned CODES       = 54,
  parameter int unsigned DUP_CARDS   = 52,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned CARD_W      = 6,
  localparam int unsigned PW = idx_w(NUM_PLAYERS),
  localparam int unsigned XW = idx_w(COLS),
  localparam int unsigned YW = idx_w(ROWS),
  localparam int unsigned LW = len_w(COLS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [2:0]                      cmd_op,
  input  logic [PW-1:0]                   cmd_player,
  input  logic [XW-1:0]                   cmd_x,
  input  logic [YW-1:0]                   cmd_y,
  input  logic [CARD_W-1:0]               cmd_card,
  input  logic [LW-1:0]                   cmd_len,
  input  logic                            cmd_dir,
  output logic                            done,
  output logic                            err,
  output logic [2:0]                      err_code,
  output logic [ROWS*COLS*CARD_W-1:0]     map,
  output logic [CODES+DUP_CARDS-1:0]      available_card,
  output logic [NUM_PLAYERS*CNT_W-1:0]    hand_cnt,
  output logic [CNT_W-1:0]                deck_cnt,
  output logic                            pick_valid
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned IW    = idx_w(CELLS);
  localparam int unsigned AV    = CODES + DUP_CARDS;
  localparam int unsigned AVW   = idx_w(AV);
  localparam logic [CARD_W-1:0] EMPTY = CARD_W'(CODES);

  state_e state_q, state_d;

  // Registered command
  op_e               op_q;
  logic [PW-1:0]     player_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [CARD_W-1:0] card_q;
  logic [LW-1:0]     len_q;
  logic              dir_q;

  // Board state
  logic [CARD_W-1:0] cells [CELLS];
  logic [CNT_W-1:0]  hands [NUM_PLAYERS];
  logic [AV-1:0]     avail_q;
  logic [CNT_W-1:0]  deck_q;
  logic              pick_valid_q;
  logic [CARD_W-1:0] pick_card_q;
  logic              pick_tbl_q;
  logic [IW-1:0]     pick_idx_q;

  logic              done_q, err_q;
  err_e              err_code_q;
  logic [LW-1:0]     step_q;

  logic [CELLS*CARD_W-1:0]       map_flat;
  logic [NUM_PLAYERS*CNT_W-1:0]  hand_flat;

  // Address arithmetic on the registered command
  int unsigned xi, yi, li, ci, pi, si, tgt;
  logic [IW-1:0]     tgt_idx, sh_dst, mv_dst, mv_src;
  logic [CARD_W-1:0] tgt_cell;
  logic              coord_ok, player_ok, last_step;
  err_e              chk;
  logic              draw_dup;

  assign xi        = 32'(x_q);
  assign yi        = 32'(y_q);
  assign li        = 32'(len_q);
  assign ci        = 32'(card_q);
  assign pi        = 32'(player_q);
  assign si        = 32'(step_q);
  assign tgt       = yi * COLS + xi;
  assign tgt_idx   = IW'(tgt);
  assign tgt_cell  = cells[tgt_idx];
  assign coord_ok  = (xi < COLS) && (yi < ROWS);
  assign player_ok = (pi < NUM_PLAYERS);
  assign last_step = (step_q == len_q - LW'(1));
  // Shift destination checked in EXEC, and per-step move pair (far end first).
  assign sh_dst    = dir_q ? IW'(tgt + li) : IW'(tgt - 1);
  assign mv_dst    = dir_q ? IW'(tgt + li - si) : IW'(tgt - 1 + si);
  assign mv_src    = dir_q ? IW'(tgt + li - si - 1) : IW'(tgt + si);

`ifdef BOARD_RESTORE_EN
  logic                          commit;
  logic [CELLS*CARD_W-1:0]       snap_map;
  logic [NUM_PLAYERS*CNT_W-1:0]  snap_hand;

  assign commit = (state_q == ST_EXEC) && (op_q == OP_COMMIT);

  board_snapshot #(
    .CELLS  (CELLS),
    .CARD_W (CARD_W),
    .CODES  (CODES),
    .HAND_W (NUM_PLAYERS * CNT_W)
  ) u_snapshot (
    .clk       (clk),
    .rst       (rst),
    .commit    (commit),
    .map_in    (map_flat),
    .hand_in   (hand_flat),
    .map_snap  (snap_map),
    .hand_snap (snap_hand)
  );
`endif

  // Legality checks for the command held in EXEC
  always_comb begin
    chk      = ERR_NONE;
    draw_dup = 1'b0;
    unique case (op_q)
      OP_TABLE_TAKE: begin
        if (!coord_ok)               chk = ERR_RANGE;
        else if (tgt_cell == EMPTY)  chk = ERR_EMPTY_SRC;
        else if (pick_valid_q)       chk = ERR_NO_PICK;
      end
      OP_TABLE_DOWN: begin
        if (!pick_valid_q)           chk = ERR_NO_PICK;
        else if (!coord_ok)          chk = ERR_RANGE;
        else if (tgt_cell != EMPTY && !(pick_tbl_q && pick_idx_q == tgt_idx))
                                     chk = ERR_OCCUPIED;
      end
      OP_SHIFT: begin
        if (!coord_ok || li == 0 ||
            (dir_q ? (xi + li > COLS - 1) : (xi == 0 || xi + li > COLS)))
                                     chk = ERR_RANGE;
        else if (cells[sh_dst] != EMPTY)
                                     chk = ERR_OCCUPIED;
      end
      OP_HAND_TAKE: begin
        if (!player_ok)              chk = ERR_RANGE;
        else if (hands[player_q] == '0)
                                     chk = ERR_EMPTY_SRC;
      end
      OP_HAND_DOWN: begin
        if (!pick_valid_q)           chk = ERR_NO_PICK;
        else if (!player_ok)         chk = ERR_RANGE;
      end
      OP_DRAW: begin
        if (!player_ok)              chk = ERR_RANGE;
        else if (ci >= CODES)        chk = ERR_UNAVAIL;
        else if (avail_q[AVW'(ci)])  chk = ERR_NONE;
        else if (ci < DUP_CARDS && avail_q[AVW'(ci + CODES)])
                                     draw_dup = 1'b1;
        else                         chk = ERR_UNAVAIL;
      end
      OP_COMMIT:                     chk = ERR_NONE;
      OP_RESTORE: begin
`ifdef BOARD_RESTORE_EN
        chk = ERR_NONE;
`else
        chk = ERR_UNSUPPORTED;
`endif
      end
      default:                       chk = ERR_NONE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC:  state_d = (op_q == OP_SHIFT && chk == ERR_NONE) ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: if (last_step) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command capture, board updates and completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_TABLE_TAKE;
      player_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      card_q       <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      for (int unsigned i = 0; i < CELLS; i++) cells[i] <= EMPTY;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) hands[i] <= '0;
      avail_q      <= '1;
      deck_q       <= CNT_W'(AV);
      pick_valid_q <= 1'b0;
      pick_card_q  <= '0;
      pick_tbl_q   <= 1'b0;
      pick_idx_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      step_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_e'(cmd_op);
            player_q <= cmd_player;
            x_q      <= cmd_x;
            y_q      <= cmd_y;
            card_q   <= cmd_card;
            len_q    <= cmd_len;
            dir_q    <= cmd_dir;
            step_q   <= '0;
          end
        end
        ST_EXEC: begin
          if (chk != ERR_NONE) begin
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= chk;
          end else begin
            done_q <= (op_q != OP_SHIFT);
            unique case (op_q)
              OP_TABLE_TAKE: begin
                pick_valid_q <= 1'b1;
                pick_card_q  <= tgt_cell;
                pick_tbl_q   <= 1'b1;
                pick_idx_q   <= tgt_idx;
              end
              OP_TABLE_DOWN: begin
                if (pick_tbl_q && pick_idx_q != tgt_idx) cells[pick_idx_q] <= EMPTY;
                cells[tgt_idx] <= pick_card_q;
                pick_valid_q   <= 1'b0;
              end
              OP_HAND_TAKE: begin
                hands[player_q] <= hands[player_q] - CNT_W'(1);
                pick_valid_q    <= 1'b1;
                pick_card_q     <= card_q;
                pick_tbl_q      <= 1'b0;
              end
              OP_HAND_DOWN: begin
                hands[player_q] <= hands[player_q] + CNT_W'(1);
                if (pick_tbl_q) cells[pick_idx_q] <= EMPTY;
                pick_valid_q    <= 1'b0;
              end
              OP_DRAW: begin
                avail_q[draw_dup ? AVW'(ci + CODES) : AVW'(ci)] <= 1'b0;
                deck_q          <= deck_q - CNT_W'(1);
                hands[player_q] <= hands[player_q] + CNT_W'(1);
              end
              OP_COMMIT: pick_valid_q <= 1'b0;
              OP_RESTORE: begin
`ifdef BOARD_RESTORE_EN
                for (int unsigned i = 0; i < CELLS; i++)
                  cells[i] <= snap_map[i*CARD_W +: CARD_W];
                for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                  hands[i] <= snap_hand[i*CNT_W +: CNT_W];
`endif
                pick_valid_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          // The source of the final step is the vacated end cell in both directions.
          cells[mv_dst] <= cells[mv_src];
          if (last_step) begin
            cells[mv_src] <= EMPTY;
            done_q        <= 1'b1;
          end
          step_q <= step_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

  // Flatten grid and hand counters onto the output buses
  always_comb begin
    map_flat  = '0;
    hand_flat = '0;
    for (int unsigned i = 0; i < CELLS; i++) map_flat[i*CARD_W +: CARD_W] = cells[i];
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) hand_flat[i*CNT_W +: CNT_W] = hands[i];
  end

  // Output decode
  always_comb begin
    cmd_ready      = (state_q == ST_IDLE);
    done           = done_q;
    err            = err_q;
    err_code       = err_code_q;
    map            = map_flat;
    hand_cnt       = hand_flat;
    available_card = avail_q;
    deck_cnt       = deck_q;
    pick_valid     = pick_valid_q;
  end

endmodule

// File: tb/tb_board_memory_ctrl.sv
// tb_board_memory_ctrl: directed scenarios plus randomized commands checked
// against a behavioural board model. Honours BOARD_RESTORE_EN.
module tb_board_memory_ctrl;

  localparam int unsigned COLS = 18, ROWS = 8, CODES = 54, DUP = 52, NP = 2, CW = 6;
  localparam int unsigned CELLS = ROWS * COLS, AV = CODES + DUP, EMPTY = CODES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_valid, cmd_ready, cmd_dir, done, err, pick_valid;
  logic [2:0] cmd_op, err_code;
  logic [0:0] cmd_player;
  logic [4:0] cmd_x;
  logic [2:0] cmd_y;
  logic [5:0] cmd_card, cmd_len;
  logic [CELLS*CW-1:0] map;
  logic [AV-1:0] available_card;
  logic [NP*7-1:0] hand_cnt;
  logic [6:0] deck_cnt;

  board_memory_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .CODES(CODES), .DUP_CARDS(DUP),
    .NUM_PLAYERS(NP), .CARD_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_player(cmd_player), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_card(cmd_card), .cmd_len(cmd_len), .cmd_dir(cmd_dir),
    .done(done), .err(err), .err_code(err_code), .map(map),
    .available_card(available_card), .hand_cnt(hand_cnt), .deck_cnt(deck_cnt),
    .pick_valid(pick_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  int unsigned m_cell [CELLS];
  int unsigned m_hand [NP];
  bit          m_avail [AV];
  int unsigned m_deck;
  bit          m_pv, m_ptbl;
  int unsigned m_pcard, m_pidx;
  int unsigned m_snap_cell [CELLS];
  int unsigned m_snap_hand [NP];

  function automatic void model_reset();
    for (int i = 0; i < CELLS; i++) begin m_cell[i] = EMPTY; m_snap_cell[i] = EMPTY; end
    for (int i = 0; i < NP; i++) begin m_hand[i] = 0; m_snap_hand[i] = 0; end
    for (int i = 0; i < AV; i++) m_avail[i] = 1'b1;
    m_deck = AV; m_pv = 0; m_ptbl = 0; m_pcard = 0; m_pidx = 0;
  endfunction

  // Applies one command to the model; returns the expected error code (0 = ok).
  function automatic int unsigned m_exec(input int unsigned op, input int unsigned p,
      input int unsigned x, input int unsigned y, input int unsigned card,
      input int unsigned len, input bit dir);
    int unsigned idx, row[COLS], nr[COLS];
    idx = y * COLS + x;
    case (op)
      0: begin
        if (m_cell[idx] == EMPTY) return 1;
        if (m_pv) return 2;
        m_pv = 1; m_pcard = m_cell[idx]; m_ptbl = 1; m_pidx = idx;
      end
      1: begin
        if (!m_pv) return 2;
        if (m_cell[idx] != EMPTY && !(m_ptbl && m_pidx == idx)) return 3;
        if (m_ptbl) m_cell[m_pidx] = EMPTY;
        m_cell[idx] = m_pcard; m_pv = 0;
      end
      2: begin
        for (int i = 0; i < COLS; i++) row[i] = m_cell[y*COLS + i];
        nr = row;
        if (len == 0) return 4;
        if (dir) begin
          if (x + len > COLS - 1) return 4;
          if (row[x+len] != EMPTY) return 3;
          for (int unsigned i = x; i < x + len; i++) nr[i+1] = row[i];
          nr[x] = EMPTY;
        end else begin
          if (x == 0 || x + len > COLS) return 4;
          if (row[x-1] != EMPTY) return 3;
          for (int unsigned i = x; i < x + len; i++) nr[i-1] = row[i];
          nr[x+len-1] = EMPTY;
        end
        for (int i = 0; i < COLS; i++) m_cell[y*COLS + i] = nr[i];
      end
      3: begin
        if (m_hand[p] == 0) return 1;
        m_hand[p]--; m_pv = 1; m_pcard = card; m_ptbl = 0;
      end
      4: begin
        if (!m_pv) return 2;
        m_hand[p]++;
        if (m_ptbl) m_cell[m_pidx] = EMPTY;
        m_pv = 0;
      end
      5: begin
        if (card >= CODES) return 5;
        if (m_avail[card]) m_avail[card] = 0;
        else if (card < DUP && m_avail[card+CODES]) m_avail[card+CODES] = 0;
        else return 5;
        m_deck--; m_hand[p]++;
      end
      6: begin
`ifdef BOARD_RESTORE_EN
        m_snap_cell = m_cell; m_snap_hand = m_hand;
`endif
        m_pv = 0;
      end
      default: begin
`ifdef BOARD_RESTORE_EN
        m_cell = m_snap_cell; m_hand = m_snap_hand; m_pv = 0;
`else
        return 6;
`endif
      end
    endcase
    return 0;
  endfunction

  function automatic logic [CELLS*CW-1:0] exp_map();
    logic [CELLS*CW-1:0] r;
    for (int i = 0; i < CELLS; i++) r[i*CW +: CW] = CW'(m_cell[i]);
    return r;
  endfunction

  function automatic logic [NP*7-1:0] exp_hand();
    logic [NP*7-1:0] r;
    for (int i = 0; i < NP; i++) r[i*7 +: 7] = 7'(m_hand[i]);
    return r;
  endfunction

  function automatic logic [AV-1:0] exp_avail();
    logic [AV-1:0] r;
    for (int i = 0; i < AV; i++) r[i] = m_avail[i];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int unsigned op, input int unsigned p, input int unsigned x,
      input int unsigned y, input int unsigned card, input int unsigned len, input bit dir);
    cmd_op = 3'(op); cmd_player = 1'(p); cmd_x = 5'(x); cmd_y = 3'(y);
    cmd_card = 6'(card); cmd_len = 6'(len); cmd_dir = dir;
  endtask

  // Sends one command, updates the model, waits for done (bounded).
  task automatic issue(input int unsigned op, input int unsigned p, input int unsigned x,
      input int unsigned y, input int unsigned card, input int unsigned len, input bit dir,
      output int unsigned exp, output bit e, output int unsigned code, output int unsigned cyc);
    bit seen;
    exp = m_exec(op, p, x, y, card, len, dir);
    @(negedge clk);
    drive(op, p, x, y, card, len, dir);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0; e = 0; code = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (done) begin seen = 1; e = err; code = 32'(err_code); end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL cmd_timeout op=%0d: no done within %0d cycles", op, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (map !== exp_map()) $display("FAIL reset_map got=%h", map); else n_pass++;
    n_checks++; if (available_card !== {AV{1'b1}}) $display("FAIL reset_avail got=%h", available_card); else n_pass++;
    n_checks++; if (deck_cnt !== 7'd106) $display("FAIL reset_deck got=%0d exp=106", deck_cnt); else n_pass++;
    n_checks++; if (hand_cnt !== '0) $display("FAIL reset_hand got=%h exp=0", hand_cnt); else n_pass++;
    n_checks++; if ({pick_valid, done, err, err_code} !== 6'b0) $display("FAIL reset_flags got=%b exp=0", {pick_valid, done, err, err_code}); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else n_pass++;
  endtask

  task automatic test_draw();
    int unsigned exp, code, cyc; bit e;
    issue(5, 0, 0, 0, 5, 0, 0, exp, e, code, cyc);
    n_checks++; if (e !== 1'b0 || available_card[5] !== 1'b0) $display("FAIL draw1 err=%b avail5=%b exp err=0 avail5=0", e, available_card[5]); else n_pass++;
    issue(5, 0, 0, 0, 5, 0, 0, exp, e, code, cyc);
    n_checks++; if (e !== 1'b0 || available_card[59] !== 1'b0) $display("FAIL draw2 err=%b avail59=%b exp err=0 avail59=0", e, available_card[59]); else n_pass++;
    n_checks++; if (deck_cnt !== 7'd104 || hand_cnt[6:0] !== 7'd2) $display("FAIL draw_counts deck=%0d hand0=%0d exp 104/2", deck_cnt, hand_cnt[6:0]); else n_pass++;
    issue(5, 0, 0, 0, 5, 0, 0, exp, e, code, cyc);
    n_checks++; if (e !== 1'b1 || code !== 5) $display("FAIL draw3 err=%b code=%0d exp err=1 code=5", e, code); else n_pass++;
    n_checks++; if (deck_cnt !== 7'(m_deck) || available_card !== exp_avail()) $display("FAIL draw3_state deck=%0d exp=%0d", deck_cnt, m_deck); else n_pass++;
  endtask

  task automatic test_hand_to_table();
    int unsigned exp, code, cyc; bit e;
    issue(3, 0, 0, 0, 7, 0, 0, exp, e, code, cyc);
    n_checks++; if (hand_cnt[6:0] !== 7'd1 || pick_valid !== 1'b1) $display("FAIL hand_take hand0=%0d pick=%b exp 1/1", hand_cnt[6:0], pick_valid); else n_pass++;
    issue(1, 0, 3, 2, 0, 0, 0, exp, e, code, cyc);
    n_checks++; if (map[39*CW +: CW] !== 6'd7 || pick_valid !== 1'b0) $display("FAIL table_down cell=%0d pick=%b exp 7/0", map[39*CW +: CW], pick_valid); else n_pass++;
    n_checks++; if (cyc !== 1 || cmd_ready !== 1'b1) $display("FAIL single_latency cyc=%0d ready=%b exp 1/1", cyc, cmd_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", done); else n_pass++;
    n_checks++; if (map !== exp_map() || hand_cnt !== exp_hand()) $display("FAIL h2t_state map/hand differ"); else n_pass++;
  endtask

  task automatic test_shift();
    int unsigned exp, code, cyc; bit e;
    for (int unsigned k = 1; k <= 3; k++) issue(5, 0, 0, 0, k, 0, 0, exp, e, code, cyc);
    for (int unsigned k = 1; k <= 3; k++) begin
      issue(3, 0, 0, 0, k, 0, 0, exp, e, code, cyc);
      issue(1, 0, k + 1, 0, 0, 0, 0, exp, e, code, cyc);
    end
    issue(2, 0, 2, 0, 0, 3, 1, exp, e, code, cyc);
    n_checks++; if (e !== 1'b0 || cyc !== 4) $display("FAIL shift_latency err=%b cyc=%0d exp 0/4", e, cyc); else n_pass++;
    n_checks++; if (map[3*CW +: CW] !== 6'd1 || map[5*CW +: CW] !== 6'd3 || map[2*CW +: CW] !== 6'd54)
      $display("FAIL shift_right c2=%0d c3=%0d c5=%0d exp 54/1/3", map[2*CW +: CW], map[3*CW +: CW], map[5*CW +: CW]); else n_pass++;
    n_checks++; if (map !== exp_map()) $display("FAIL shift_right_map map differs from model"); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int unsigned busy = 0, cyc = 0; bit seen = 0;
    void'(m_exec(2, 0, 3, 0, 0, 3, 0));
    @(negedge clk); drive(2, 0, 3, 0, 0, 3, 0); cmd_valid = 1'b1;
    @(posedge clk); #1;
    drive(5, 1, 0, 0, 10, 0, 0);
    while (!seen && cyc < 40) begin
      if (!cmd_ready) busy++;
      @(posedge clk); #1; cyc++;
      if (done) begin seen = 1; cmd_valid = 1'b0; end
    end
    cmd_valid = 1'b0;
    n_checks++; if (!seen || busy !== 4) $display("FAIL busy_window seen=%b busy=%0d exp 1/4", seen, busy); else n_pass++;
    n_checks++; if (available_card[10] !== 1'b1 || hand_cnt[13:7] !== 7'd0) $display("FAIL busy_ignored avail10=%b hand1=%0d exp 1/0", available_card[10], hand_cnt[13:7]); else n_pass++;
    n_checks++; if (map !== exp_map()) $display("FAIL shift_left_map map differs from model"); else n_pass++;
  endtask

  task automatic test_shift_errors();
    int unsigned exp, code, cyc; bit e;
    int unsigned tx [5] = '{16, 2, 0, 2, 3};
    int unsigned tl [5] = '{2, 0, 1, 2, 2};
    bit          td [5] = '{1, 1, 0, 1, 0};
    int unsigned tc [5] = '{4, 4, 4, 3, 3};
    for (int i = 0; i < 5; i++) begin
      issue(2, 0, tx[i], 0, 0, tl[i], td[i], exp, e, code, cyc);
      n_checks++; if (e !== 1'b1 || code !== tc[i] || code !== exp) $display("FAIL shift_err%0d err=%b code=%0d exp code=%0d", i, e, code, tc[i]); else n_pass++;
    end
    n_checks++; if (map !== exp_map()) $display("FAIL shift_err_map map changed"); else n_pass++;
  endtask

  task automatic test_restore();
    int unsigned exp, code, cyc; bit e;
    logic [CELLS*CW-1:0] committed;
    issue(6, 0, 0, 0, 0, 0, 0, exp, e, code, cyc);
    committed = map;
    issue(0, 0, 3, 0, 0, 0, 0, exp, e, code, cyc);
    issue(1, 0, 0, 5, 0, 0, 0, exp, e, code, cyc);
    n_checks++; if (map[90*CW +: CW] !== 6'd2 || map[3*CW +: CW] !== 6'd54) $display("FAIL move_before_restore c90=%0d c3=%0d exp 2/54", map[90*CW +: CW], map[3*CW +: CW]); else n_pass++;
    issue(7, 0, 0, 0, 0, 0, 0, exp, e, code, cyc);
`ifdef BOARD_RESTORE_EN
    n_checks++; if (e !== 1'b0 || map !== committed) $display("FAIL restore err=%b map_matches=%b exp 0/1", e, map === committed); else n_pass++;
`else
    n_checks++; if (e !== 1'b1 || code !== 6 || map === committed) $display("FAIL restore_unsup err=%b code=%0d exp 1/6", e, code); else n_pass++;
`endif
    n_checks++; if (map !== exp_map() || hand_cnt !== exp_hand() || pick_valid !== m_pv) $display("FAIL restore_state differs from model"); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned op, exp, code, cyc; bit e;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op > 7) op = 5;
      issue(op, $urandom_range(0, 1), $urandom_range(0, 17), $urandom_range(0, 2),
            $urandom_range(0, 57), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
            exp, e, code, cyc);
      n_checks++; if (e !== (exp != 0) || code !== exp) $display("FAIL rand%0d op=%0d err=%b code=%0d exp code=%0d", n, op, e, code, exp); else n_pass++;
      if (n % 25 == 24) begin
        n_checks++;
        if (map !== exp_map() || hand_cnt !== exp_hand() || available_card !== exp_avail() ||
            deck_cnt !== 7'(m_deck) || pick_valid !== m_pv)
          $display("FAIL rand_state%0d deck=%0d exp=%0d pick=%b exp=%b", n, deck_cnt, m_deck, pick_valid, m_pv);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int unsigned exp, code, cyc; bit e;
    do_reset();
    for (int unsigned k = 1; k <= 4; k++) issue(5, 0, 0, 0, k, 0, 0, exp, e, code, cyc);
    for (int unsigned k = 0; k < 4; k++) begin
      issue(3, 0, 0, 0, k + 1, 0, 0, exp, e, code, cyc);
      issue(1, 0, k, 0, 0, 0, 0, exp, e, code, cyc);
    end
    @(negedge clk); drive(2, 0, 0, 0, 0, 4, 1); cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_checks++; if (map !== exp_map()) $display("FAIL mid_shift_map cells not all empty"); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL mid_shift_flags ready=%b done=%b exp 1/0", cmd_ready, done); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_draw();
    test_hand_to_table();
    test_shift();
    test_busy_ignore();
    test_shift_errors();
    test_restore();
    test_random();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
